// File: rtl/wb_burst_master_if.sv
// Command, write-data, response and Wishbone bus bundle for wb_burst_master.
// The master modport is the block's view; the slave modport is the environment's view.
interface wb_burst_master_if #(
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int LENW = 3
);
   localparam int SW = DW / 8;

   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_we;
   logic [AW-1:0]   cmd_adr;
   logic [LENW-1:0] cmd_len;
   logic [SW-1:0]   cmd_sel;

   logic            wdat_valid;
   logic            wdat_ready;
   logic [DW-1:0]   wdat;

   logic            rsp_valid;
   logic [DW-1:0]   rsp_dat;
   logic            rsp_last;
   logic [1:0]      rsp_status;

   logic [AW-1:0]   ADR_O;
   logic [DW-1:0]   DAT_O;
   logic [SW-1:0]   SEL_O;
   logic            WE_O;
   logic            CYC_O;
   logic            STB_O;
   logic [DW-1:0]   DAT_I;
   logic            ACK_I;
   logic            ERR_I;
   logic            RTY_I;

   modport master (
      input  cmd_valid, cmd_we, cmd_adr, cmd_len, cmd_sel,
      output cmd_ready,
      input  wdat_valid, wdat,
      output wdat_ready,
      output rsp_valid, rsp_dat, rsp_last, rsp_status,
      output ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O,
      input  DAT_I, ACK_I, ERR_I, RTY_I
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_adr, cmd_len, cmd_sel,
      input  cmd_ready,
      output wdat_valid, wdat,
      input  wdat_ready,
      input  rsp_valid, rsp_dat, rsp_last, rsp_status,
      input  ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O,
      output DAT_I, ACK_I, ERR_I, RTY_I
   );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone classic-cycle burst master: runs single/incrementing bursts from a command port,
// with ERR abort, bounded RTY retry with one-cycle backoff, and a no-response watchdog.
module wb_burst_master #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int LENW      = 3,
   parameter int RETRY_MAX = 4,
   parameter int TIMEOUT   = 256
) (
   input  logic              CLK_I,
   input  logic              RST_NI,
   wb_burst_master_if.master bus
);
   localparam int SW  = DW / 8;
   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDW-1:0] WD_LAST   = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [3:0]     RETRY_LIM = 4'(RETRY_MAX);

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_RTY = 2'b10;
   localparam logic [1:0] ST_TMO = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDAT,
      S_BUS,
      S_GAP,
      S_BACKOFF,
      S_DONE
   } state_t;

   state_t          state_q;
   logic            cmd_ready_q;
   logic            wdat_ready_q;
   logic            we_q;
   logic [AW-1:0]   adr_q;
   logic [LENW-1:0] len_q;
   logic [SW-1:0]   sel_q;
   logic [DW-1:0]   dat_o_q;
   logic            cyc_q;
   logic            stb_q;
   logic [LENW-1:0] beat_q;
   logic [3:0]      retry_q;
   logic [WDW-1:0]  wd_q;
   logic            rsp_valid_q;
   logic            rsp_last_q;
   logic [DW-1:0]   rsp_dat_q;
   logic [1:0]      rsp_status_q;

   logic [AW-1:0]   adr_d;
   logic [LENW-1:0] beat_d;
   logic [3:0]      retry_d;
   logic [WDW-1:0]  wd_d;
   logic            last_beat;
   logic            timeout_hit;

   // Address wraps modulo 2^AW by plain truncation of the sum.
   assign adr_d       = adr_q + AW'(SW);
   assign beat_d      = beat_q + LENW'(1);
   assign retry_d     = retry_q + 4'd1;
   assign wd_d        = wd_q + WDW'(1);
   assign last_beat   = (beat_q == len_q);
   assign timeout_hit = (TIMEOUT != 0) && (wd_q == WD_LAST);

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         state_q      <= S_IDLE;
         cmd_ready_q  <= 1'b0;
         wdat_ready_q <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         len_q        <= '0;
         sel_q        <= '0;
         dat_o_q      <= '0;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         beat_q       <= '0;
         retry_q      <= '0;
         wd_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_last_q   <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= ST_OK;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (bus.cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  we_q        <= bus.cmd_we;
                  adr_q       <= bus.cmd_adr;
                  len_q       <= bus.cmd_len;
                  sel_q       <= bus.cmd_we ? bus.cmd_sel : '1;
                  beat_q      <= '0;
                  retry_q     <= '0;
                  wd_q        <= '0;
                  if (bus.cmd_we) begin
                     wdat_ready_q <= 1'b1;
                     state_q      <= S_WDAT;
                  end else begin
                     cyc_q   <= 1'b1;
                     stb_q   <= 1'b1;
                     state_q <= S_BUS;
                  end
               end
            end

            S_WDAT: begin
               if (bus.wdat_valid) begin
                  dat_o_q      <= bus.wdat;
                  wdat_ready_q <= 1'b0;
                  cyc_q        <= 1'b1;
                  stb_q        <= 1'b1;
                  wd_q         <= '0;
                  state_q      <= S_BUS;
               end
            end

            // ERR wins over RTY, RTY over ACK when sampled on the same edge.
            S_BUS: begin
               if (bus.ERR_I) begin
                  cyc_q        <= 1'b0;
                  stb_q        <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  rsp_last_q   <= 1'b1;
                  rsp_dat_q    <= '0;
                  rsp_status_q <= ST_ERR;
                  state_q      <= S_DONE;
               end else if (bus.RTY_I) begin
                  retry_q <= retry_d;
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  if (retry_d == RETRY_LIM) begin
                     rsp_valid_q  <= 1'b1;
                     rsp_last_q   <= 1'b1;
                     rsp_dat_q    <= '0;
                     rsp_status_q <= ST_RTY;
                     state_q      <= S_DONE;
                  end else begin
                     state_q <= S_BACKOFF;
                  end
               end else if (bus.ACK_I) begin
                  retry_q      <= '0;
                  stb_q        <= 1'b0;
                  rsp_valid_q  <= !we_q || last_beat;
                  rsp_dat_q    <= we_q ? '0 : bus.DAT_I;
                  rsp_status_q <= ST_OK;
                  if (last_beat) begin
                     cyc_q      <= 1'b0;
                     rsp_last_q <= 1'b1;
                     state_q    <= S_DONE;
                  end else begin
                     adr_q   <= adr_d;
                     beat_q  <= beat_d;
                     state_q <= S_GAP;
                  end
               end else if (timeout_hit) begin
                  cyc_q        <= 1'b0;
                  stb_q        <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  rsp_last_q   <= 1'b1;
                  rsp_dat_q    <= '0;
                  rsp_status_q <= ST_TMO;
                  state_q      <= S_DONE;
               end else begin
                  wd_q <= wd_d;
               end
            end

            // CYC stays high here so the burst remains one bus cycle.
            S_GAP: begin
               if (we_q) begin
                  wdat_ready_q <= 1'b1;
                  state_q      <= S_WDAT;
               end else begin
                  stb_q   <= 1'b1;
                  wd_q    <= '0;
                  state_q <= S_BUS;
               end
            end

            S_BACKOFF: begin
               cyc_q   <= 1'b1;
               stb_q   <= 1'b1;
               wd_q    <= '0;
               state_q <= S_BUS;
            end

            S_DONE: begin
               cmd_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.wdat_ready = wdat_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_dat    = rsp_dat_q;
   assign bus.rsp_last   = rsp_last_q;
   assign bus.rsp_status = rsp_status_q;
   assign bus.ADR_O      = adr_q;
   assign bus.DAT_O      = dat_o_q;
   assign bus.SEL_O      = sel_q;
   assign bus.WE_O       = we_q;
   assign bus.CYC_O      = cyc_q;
   assign bus.STB_O      = stb_q;
endmodule
